// File: rtl/mod_demod_loop.sv
// mod_demod_loop: gyro closed-loop front end. Generates the square-wave bias
// modulation and its edge trigger, demodulates detector samples in step with
// the modulation, and integrates the per-period error into the feedback step.
// Optional build macro: STEP_SAT_EN -- when defined, the feedback step
// saturates at +/-(2^(OUTPUT_BIT-1)-1); otherwise it wraps in 32 bits.
module mod_demod_loop #(
    parameter int OUTPUT_BIT = 16,
    parameter int ADC_BIT    = 14,
    parameter int CNT_BIT    = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic        [CNT_BIT-1:0]    i_freq,
    input  logic        [CNT_BIT-1:0]    i_wait_cnt,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_h,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_l,
    input  logic signed [ADC_BIT-1:0]    i_adc,
    input  logic        [4:0]            i_gain_sel,
    input  logic                         i_loop_en,
    output logic signed [OUTPUT_BIT-1:0] o_mod,
    output logic                         o_trig,
    output logic signed [31:0]           o_err,
    output logic                         o_err_vld,
    output logic signed [31:0]           o_step
);

    typedef enum logic {
        ST_HIGH = 1'b0,
        ST_LOW  = 1'b1
    } phase_t;

    localparam logic [CNT_BIT-1:0] FREQ_MIN = CNT_BIT'(2);

`ifdef STEP_SAT_EN
    localparam logic signed [32:0] STEP_MAX = (33'sd1 <<< (OUTPUT_BIT - 1)) - 33'sd1;

    // Clamp a widened step sum back into the symmetric saturation window.
    function automatic logic signed [31:0] step_limit(input logic signed [32:0] val);
        logic signed [31:0] res;
        if (val > STEP_MAX) begin
            res = STEP_MAX[31:0];
        end else if (val < -STEP_MAX) begin
            res = -STEP_MAX[31:0];
        end else begin
            res = val[31:0];
        end
        return res;
    endfunction
`endif

    phase_t                      state_q, state_d;
    logic        [CNT_BIT-1:0]   cnt_q, cnt_d;
    logic        [CNT_BIT-1:0]   f_q, f_d;
    logic        [CNT_BIT-1:0]   w_q, w_d;
    logic signed [31:0]          sum_h_q, sum_h_d;
    logic signed [31:0]          sum_l_q, sum_l_d;
    logic signed [OUTPUT_BIT-1:0] mod_q, mod_d;
    logic                        trig_q, trig_d;
    logic signed [31:0]          err_q, err_d;
    logic                        vld_q, vld_d;
    logic signed [31:0]          step_q, step_d;

    logic                        period_start_s;
    logic        [CNT_BIT-1:0]   f_eff_s;
    logic        [CNT_BIT-1:0]   w_eff_s;
    logic                        last_s;
    logic signed [31:0]          adc_ext_s;
    logic signed [31:0]          sample_s;
    logic signed [31:0]          sum_l_full_s;
    logic signed [31:0]          step_shift_s;
    logic signed [31:0]          step_next_s;
`ifdef STEP_SAT_EN
    logic signed [32:0]          step_sum_s;
`endif

    // Phase sequencing, half-period timing and demodulation sums.
    always_comb begin
        // F and W come straight from the inputs on the first clock of a
        // period, so a new setting governs that whole period.
        period_start_s = (state_q == ST_HIGH) && (cnt_q == CNT_BIT'(0));
        if (period_start_s) begin
            f_eff_s = (i_freq < FREQ_MIN) ? FREQ_MIN : i_freq;
            w_eff_s = i_wait_cnt;
        end else begin
            f_eff_s = f_q;
            w_eff_s = w_q;
        end
        last_s       = (cnt_q == (f_eff_s - CNT_BIT'(1)));
        adc_ext_s    = {{(32 - ADC_BIT){i_adc[ADC_BIT-1]}}, i_adc};
        sample_s     = (cnt_q >= w_eff_s) ? adc_ext_s : 32'sd0;
        sum_l_full_s = sum_l_q + sample_s;

        state_d = state_q;
        cnt_d   = cnt_q + CNT_BIT'(1);
        f_d     = f_eff_s;
        w_d     = w_eff_s;
        sum_h_d = sum_h_q;
        sum_l_d = sum_l_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        trig_d  = last_s;

        case (state_q)
            ST_HIGH: begin
                sum_h_d = sum_h_q + sample_s;
                if (last_s) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_BIT'(0);
                    sum_l_d = 32'sd0;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    err_d   = sum_h_q - sum_l_full_s;
                    vld_d   = 1'b1;
                    sum_h_d = 32'sd0;
                    sum_l_d = 32'sd0;
                    state_d = ST_HIGH;
                    cnt_d   = CNT_BIT'(0);
                end else begin
                    sum_l_d = sum_l_full_s;
                end
            end
            default: begin
                state_d = ST_HIGH;
                cnt_d   = CNT_BIT'(0);
                sum_h_d = 32'sd0;
                sum_l_d = 32'sd0;
            end
        endcase

        // Level follows the phase being entered, so it moves with o_trig.
        mod_d = (state_d == ST_HIGH) ? i_amp_h : i_amp_l;
    end

    // Feedback integrator: one update per fresh error word, cleared when open-loop.
    always_comb begin
        step_shift_s = err_q >>> i_gain_sel;
`ifdef STEP_SAT_EN
        step_sum_s   = {step_q[31], step_q} + {step_shift_s[31], step_shift_s};
        step_next_s  = step_limit(step_sum_s);
`else
        step_next_s  = step_q + step_shift_s;
`endif
        if (!i_loop_en) begin
            step_d = 32'sd0;
        end else if (vld_q) begin
            step_d = step_next_s;
        end else begin
            step_d = step_q;
        end
    end

    // State and output registers; async reset drops any partial period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_BIT'(0);
            f_q     <= FREQ_MIN;
            w_q     <= CNT_BIT'(0);
            sum_h_q <= 32'sd0;
            sum_l_q <= 32'sd0;
            mod_q   <= '0;
            trig_q  <= 1'b0;
            err_q   <= 32'sd0;
            vld_q   <= 1'b0;
            step_q  <= 32'sd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            w_q     <= w_d;
            sum_h_q <= sum_h_d;
            sum_l_q <= sum_l_d;
            mod_q   <= mod_d;
            trig_q  <= trig_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            step_q  <= step_d;
        end
    end

    assign o_mod     = mod_q;
    assign o_trig    = trig_q;
    assign o_err     = err_q;
    assign o_err_vld = vld_q;
    assign o_step    = step_q;

endmodule

// File: tb/tb_mod_demod_loop.sv
// Bench for mod_demod_loop: table of directed configurations, hand-written
// corner sequences and randomized runs, all checked against a period-level
// reference model (position in period, sample lists summed at period end).
module tb_mod_demod_loop;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic        [15:0] i_freq;
    logic        [15:0] i_wait_cnt;
    logic signed [15:0] i_amp_h;
    logic signed [15:0] i_amp_l;
    logic signed [13:0] i_adc;
    logic        [4:0]  i_gain_sel;
    logic               i_loop_en;
    logic signed [15:0] o_mod;
    logic               o_trig;
    logic signed [31:0] o_err;
    logic               o_err_vld;
    logic signed [31:0] o_step;

    always #5 i_clk = ~i_clk;

    mod_demod_loop dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_freq(i_freq), .i_wait_cnt(i_wait_cnt),
        .i_amp_h(i_amp_h), .i_amp_l(i_amp_l), .i_adc(i_adc), .i_gain_sel(i_gain_sel),
        .i_loop_en(i_loop_en), .o_mod(o_mod), .o_trig(o_trig), .o_err(o_err),
        .o_err_vld(o_err_vld), .o_step(o_step)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_t, m_F, m_W, m_err, m_step, m_mod;
    bit m_vld, m_trig;
    int qh[$];
    int ql[$];
    int a_hi, a_lo;
    bit rand_adc;

    typedef struct {
        int freq; int wt; int amp_h; int amp_l; int adc_h; int adc_l;
        int gain; bit en; int periods; int exp_err; int exp_step;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_F = 2; m_W = 0; m_err = 0; m_step = 0; m_mod = 0;
        m_vld = 0; m_trig = 0;
        qh.delete(); ql.delete();
    endtask

    task automatic model_edge();
        int pos, sh, sl;
        longint s;
        if (m_t == 0) begin
            m_F = (i_freq < 16'd2) ? 2 : int'(i_freq);
            m_W = int'(i_wait_cnt);
        end
        pos = m_t % m_F;
        if (pos >= m_W) begin
            if (m_t < m_F) qh.push_back(int'(i_adc));
            else           ql.push_back(int'(i_adc));
        end
        if (!i_loop_en) m_step = 0;
        else if (m_vld) begin
            s = longint'(m_step) + longint'(m_err >>> i_gain_sel);
`ifdef STEP_SAT_EN
            if (s > 32767) s = 32767;
            if (s < -32767) s = -32767;
`endif
            m_step = int'(s);
        end
        m_trig = (pos == m_F - 1);
        m_vld  = 0;
        if (m_t == 2 * m_F - 1) begin
            sh = 0; sl = 0;
            foreach (qh[k]) sh += qh[k];
            foreach (ql[k]) sl += ql[k];
            m_err = sh - sl;
            m_vld = 1;
            qh.delete(); ql.delete();
            m_t = 0;
        end else begin
            m_t++;
        end
        m_mod = (m_t < m_F) ? int'(i_amp_h) : int'(i_amp_l);
    endtask

    task automatic compare_all();
        check("o_mod",     longint'(o_mod),  longint'(m_mod));
        check("o_trig",    longint'(o_trig), longint'(m_trig));
        check("o_err",     longint'(o_err),  longint'(m_err));
        check("o_err_vld", longint'(o_err_vld), longint'(m_vld));
        check("o_step",    longint'(o_step), longint'(m_step));
    endtask

    task automatic drive_adc();
        if (rand_adc) i_adc = 14'($urandom);
        else          i_adc = (m_t < m_F) ? 14'(a_hi) : 14'(a_lo);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all();
        drive_adc();
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        model_reset();
        drive_adc();
        #2;
        compare_all();
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
    endtask

    task automatic setup(input int f, input int w, input int ah, input int al,
                         input int dh, input int dl, input int g, input bit en);
        i_freq = 16'(f); i_wait_cnt = 16'(w); i_amp_h = 16'(ah); i_amp_l = 16'(al);
        a_hi = dh; a_lo = dl; i_gain_sel = 5'(g); i_loop_en = en; rand_adc = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe, e, n, nv;
        int trig_at[4];
        int exp_trig[4];
        bit found;

        //           freq wt  ah    al   adch adcl gain en per err   step
        tbl[0] = '{4, 1, 100, -100,  50,  50, 0, 1'b1, 5,    0,    0};
        tbl[1] = '{4, 1, 100, -100,  20, -20, 0, 1'b1, 3,  120,  360};
        tbl[2] = '{4, 1, 100, -100,  20, -20, 2, 1'b1, 3,  120,   90};
        tbl[3] = '{4, 1, 100, -100, -20,  20, 2, 1'b1, 3, -120,  -90};
        tbl[4] = '{4, 5, 300, -300,  77, -33, 0, 1'b1, 3,    0,    0};
        tbl[5] = '{3, 0,  10,  -10,   7,  -5, 1, 1'b1, 4,   36,   72};
        tbl[6] = '{4, 1, 100, -100,  20, -20, 0, 1'b0, 3,  120,    0};
        tbl[7] = '{1, 0,  55,  -55,  10, -10, 0, 1'b1, 3,   40,  120};

        i_rst_n = 1'b0;
        setup(4, 1, 0, 0, 0, 0, 0, 1'b1);
        model_reset();
        drive_adc();

        // directed table
        for (int i = 0; i < 8; i++) begin
            setup(tbl[i].freq, tbl[i].wt, tbl[i].amp_h, tbl[i].amp_l,
                  tbl[i].adc_h, tbl[i].adc_l, tbl[i].gain, tbl[i].en);
            apply_reset();
            fe = (tbl[i].freq < 2) ? 2 : tbl[i].freq;
            repeat (2 * fe * tbl[i].periods + 2) tick();
            check($sformatf("tbl%0d_err", i),  longint'(o_err),  longint'(tbl[i].exp_err));
            check($sformatf("tbl%0d_step", i), longint'(o_step), longint'(tbl[i].exp_step));
        end

        // freq change mid-HIGH takes effect only at the next period start
        setup(4, 1, 100, -100, 20, -20, 0, 1'b1);
        apply_reset();
        e = 0; n = 0;
        tick(); tick(); e = 2;
        i_freq = 16'd8;
        while (n < 4 && e < 80) begin
            tick(); e++;
            if (o_trig) begin trig_at[n] = e; n++; end
        end
        exp_trig[0] = 4; exp_trig[1] = 8; exp_trig[2] = 16; exp_trig[3] = 24;
        for (int k = 0; k < 4; k++)
            check($sformatf("freq_change_trig%0d", k), longint'((k < n) ? trig_at[k] : -1),
                  longint'(exp_trig[k]));

        // reset mid-LOW clears outputs at once; first trig F clocks after release
        setup(4, 1, 100, -100, 20, -20, 0, 1'b1);
        apply_reset();
        repeat (2 * 8 + 5) tick();
        i_rst_n = 1'b0;
        #1;
        check("rst_async_mod",  longint'(o_mod),  0);
        check("rst_async_err",  longint'(o_err),  0);
        check("rst_async_step", longint'(o_step), 0);
        check("rst_async_trig", longint'(o_trig), 0);
        apply_reset();
        found = 0; n = 0; e = 0;
        while (!found && e < 20) begin
            tick(); e++;
            if (o_trig) begin found = 1; n = e; end
        end
        check("trig_after_reset", longint'(n), 4);

        // dropping loop enable zeroes the step next clock; error keeps updating
        repeat (20) tick();
        i_loop_en = 1'b0;
        tick();
        check("loop_off_step", longint'(o_step), 0);
        nv = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (o_err_vld) nv++;
        end
        check("loop_off_vld_count", longint'(nv), 2);
        check("loop_off_err", longint'(o_err), 120);

        // step limit behaviour
        setup(2, 0, 1000, -1000, 8000, -8000, 0, 1'b1);
        apply_reset();
        repeat (2 * 2 * 2 + 2) tick();
`ifdef STEP_SAT_EN
        check("sat_step2", longint'(o_step), 32767);
`else
        check("wrap_step2", longint'(o_step), 64000);
`endif
        repeat (4) tick();
`ifdef STEP_SAT_EN
        check("sat_step3", longint'(o_step), 32767);
`else
        check("wrap_step3", longint'(o_step), 96000);
`endif
        a_hi = -8000; a_lo = 8000;
        repeat (12) tick();

        // randomized runs against the model
        for (int seg = 0; seg < 10; seg++) begin
            i_freq = 16'($urandom_range(0, 9));
            i_wait_cnt = 16'($urandom_range(0, 10));
            i_amp_h = 16'($urandom);
            i_amp_l = 16'($urandom);
            i_gain_sel = 5'($urandom_range(0, 8));
            i_loop_en = ($urandom_range(0, 7) != 0);
            rand_adc = 1'b1;
            if (seg % 3 == 0) apply_reset();
            for (int c = 0; c < 150; c++) begin
                tick();
                if ($urandom_range(0, 19) == 0) i_freq = 16'($urandom_range(0, 9));
                if ($urandom_range(0, 19) == 0) i_wait_cnt = 16'($urandom_range(0, 10));
                if ($urandom_range(0, 29) == 0) i_gain_sel = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 29) == 0) i_loop_en = ~i_loop_en;
                if ($urandom_range(0, 39) == 0) i_amp_h = 16'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
